gf180_ram_tiled: RTL and testbench

- Parametrised SRAM subsystem built by tiling gf180mcu_fd_ip_sram__sram128x8m8wm1 macros into a DEPTH_BLKS x (DATA_W/8) array.
- Provides a valid/ready request port, a fixed-latency read-response port, byte write enables and a hardware zero-fill after reset.
- Serves as the general on-chip memory block for register files, tile buffers and scratchpads behind the core.

---
 rtl/gf180_ram_tiled_if.sv | 26 ++
 rtl/gf180_ram_tiled.sv | 192 +++++++++++++++++++
 tb/tb_gf180_ram_tiled.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/gf180_ram_tiled_if.sv
// Request/response bus for gf180_ram_tiled.
// The master drives requests; the slave (the memory) returns ready, read data and init status.
interface gf180_ram_tiled_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [DATA_W/8-1:0]   REQ_BE;
  logic [ADDR_W-1:0]     REQ_ADDR;
  logic [DATA_W-1:0]     REQ_WDATA;
  logic                  RSP_VALID;
  logic [DATA_W-1:0]     RSP_RDATA;
  logic                  INIT_DONE;

  modport master (
    output REQ_VALID, REQ_WE, REQ_BE, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, INIT_DONE
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_BE, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, INIT_DONE
  );
endinterface

// File: rtl/gf180_ram_tiled.sv
// Tiled SRAM built from a DEPTH_BLKS x (DATA_W/8) array of 128x8 macros
// (gf180mcu_fd_ip_sram__sram128x8m8wm1 behaviour modelled inline).
// After reset the whole array is zero-filled over 128 cycles, then one request per cycle is
// accepted. Reads return data after 1 cycle, or 2 cycles when GF180_RAM_TILED_OUT_REG_EN is
// defined (adds an output register after the row mux).
module gf180_ram_tiled #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_BLKS = 2,
  localparam int unsigned ADDR_W    = 7 + $clog2(DEPTH_BLKS)
) (
  input  logic              CLK,
  input  logic              RST,
  gf180_ram_tiled_if.slave  mem_if
);

  localparam int unsigned NumCols = DATA_W / 8;
  localparam int unsigned RowW    = (DEPTH_BLKS > 1) ? $clog2(DEPTH_BLKS) : 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;

  logic [RowW-1:0]     req_row;
  logic [6:0]          req_word;
  logic                req_fire;
  logic                rd_fire;

  // Macro control, shared A/D/WEN; CEN/GWEN per row
  logic [DEPTH_BLKS-1:0] m_cen;
  logic [DEPTH_BLKS-1:0] m_gwen;
  logic [DATA_W-1:0]     m_wen;
  logic [6:0]            m_a;
  logic [DATA_W-1:0]     m_d;
  logic [DATA_W-1:0]     row_q [DEPTH_BLKS];

  logic                rd_pend_q;
  logic [RowW-1:0]     rd_row_q;
  logic [DATA_W-1:0]   mux_data;

  if (DEPTH_BLKS > 1) begin : g_row_sel
    assign req_row = mem_if.REQ_ADDR[ADDR_W-1:7];
  end else begin : g_row_one
    assign req_row = '0;
  end
  assign req_word = mem_if.REQ_ADDR[6:0];

  // A write with no byte enables is accepted but touches nothing.
  assign req_fire = (state_q == StRun) && mem_if.REQ_VALID &&
                    (!mem_if.REQ_WE || (|mem_if.REQ_BE));
  assign rd_fire  = req_fire && !mem_if.REQ_WE;

  assign mem_if.REQ_READY = (state_q == StRun);
  assign mem_if.INIT_DONE = (state_q == StRun);

  // State and fill counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fill sequencing: walk c = 0..127 then enter RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Macro pin decode: fill writes every macro, requests enable only the addressed row
  always_comb begin
    m_cen  = '1;
    m_gwen = '1;
    m_wen  = '1;
    m_a    = req_word;
    m_d    = mem_if.REQ_WDATA;
    if (!RST && (state_q == StInit)) begin
      m_cen  = '0;
      m_gwen = '0;
      m_wen  = '0;
      m_a    = cnt_q;
      m_d    = '0;
    end else if (!RST && req_fire) begin
      for (int r = 0; r < int'(DEPTH_BLKS); r++) begin
        if (req_row == RowW'(r)) begin
          m_cen[r]  = 1'b0;
          m_gwen[r] = !mem_if.REQ_WE;
        end
      end
      if (mem_if.REQ_WE) begin
        for (int k = 0; k < int'(NumCols); k++) begin
          m_wen[k*8 +: 8] = {8{!mem_if.REQ_BE[k]}};
        end
      end
    end
  end

  for (genvar r = 0; r < int'(DEPTH_BLKS); r++) begin : g_row
    logic [NumCols-1:0][7:0] q_cols;
    for (genvar k = 0; k < int'(NumCols); k++) begin : g_col
      logic [7:0] mem_q [128];
      logic [7:0] q_q;
      logic [7:0] wr_word;

      // Bit-masked merge of new data into the stored word (WEN low = write bit)
      assign wr_word = (mem_q[m_a] & m_wen[k*8 +: 8]) | (m_d[k*8 +: 8] & ~m_wen[k*8 +: 8]);

      // Macro core: synchronous write-through, Q holds while deselected
      always_ff @(posedge CLK) begin
        if (!m_cen[r]) begin
          if (!m_gwen[r]) begin
            mem_q[m_a] <= wr_word;
            q_q        <= wr_word;
          end else begin
            q_q <= mem_q[m_a];
          end
        end
      end

      assign q_cols[k] = q_q;
    end
    assign row_q[r] = q_cols;
  end

  // Read tracking: pending flag and registered row select for the output mux
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend_q <= 1'b0;
      rd_row_q  <= '0;
    end else begin
      rd_pend_q <= rd_fire;
      if (rd_fire) begin
        rd_row_q <= req_row;
      end
    end
  end

  assign mux_data = row_q[rd_row_q];

`ifdef GF180_RAM_TILED_OUT_REG_EN
  logic              out_vld_q;
  logic [DATA_W-1:0] out_data_q;

  // Output pipeline stage: loads only on a response, otherwise holds
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_vld_q <= rd_pend_q;
      if (rd_pend_q) begin
        out_data_q <= mux_data;
      end
    end
  end

  assign mem_if.RSP_VALID = out_vld_q;
  assign mem_if.RSP_RDATA = out_data_q;
`else
  logic [DATA_W-1:0] hold_q;

  // Capture each response so RSP_RDATA stays stable once the macro Q moves on
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q <= '0;
    end else if (rd_pend_q) begin
      hold_q <= mux_data;
    end
  end

  assign mem_if.RSP_VALID = rd_pend_q;
  assign mem_if.RSP_RDATA = rd_pend_q ? mux_data : hold_q;
`endif

endmodule

// File: tb/tb_gf180_ram_tiled.sv
// Directed, table-driven bench for gf180_ram_tiled (DATA_W=16, DEPTH_BLKS=2).
module tb_gf180_ram_tiled;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DEPTH_BLKS = 2;
  localparam int unsigned ADDR_W     = 8;
`ifdef GF180_RAM_TILED_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  gf180_ram_tiled_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gf180_ram_tiled #(.DATA_W(DATA_W), .DEPTH_BLKS(DEPTH_BLKS)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .mem_if (bus)
  );

  typedef struct {
    logic        vld;
    logic        we;
    logic [1:0]  be;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;   // expected read data (reads only)
  } vec_t;

  vec_t        tbl[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] exp_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic vld, input logic we, input logic [1:0] be,
                              input logic [7:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp);
    vec_t v;
    v.vld = vld; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    bus.REQ_VALID = v.vld;
    bus.REQ_WE    = v.we;
    bus.REQ_BE    = v.be;
    bus.REQ_ADDR  = v.addr;
    bus.REQ_WDATA = v.wdata;
  endtask

  task automatic drive_idle();
    bus.REQ_VALID = 1'b0;
    bus.REQ_WE    = 1'b0;
    bus.REQ_BE    = 2'b00;
    bus.REQ_ADDR  = 8'h00;
    bus.REQ_WDATA = 16'h0000;
  endtask

  // Release reset and count edges until INIT_DONE, driving a read that must be ignored
  task automatic wait_init(input string tag);
    int   cyc;
    logic rdy_seen;
    logic rsp_seen;
    cyc = 0; rdy_seen = 1'b0; rsp_seen = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = 8'h10;
    while (!bus.INIT_DONE && cyc < 300) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (bus.REQ_READY && !bus.INIT_DONE) rdy_seen = 1'b1;
      if (bus.RSP_VALID) rsp_seen = 1'b1;
    end
    check({tag, "_init_cycles"}, cyc, 128);
    check({tag, "_ready_in_init"}, {31'd0, rdy_seen}, 0);
    check({tag, "_rsp_in_init"}, {31'd0, rsp_seen}, 0);
    @(negedge CLK);
    drive_idle();
    check({tag, "_ready_run"}, {31'd0, bus.REQ_READY}, 1);
  endtask

  // Apply tbl one entry per cycle; response for entry j is expected Lat-1 entries later
  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      int   j;
      logic ev;
      drive(tbl[i]);
      @(posedge CLK);
      @(negedge CLK);
      j  = i - (Lat - 1);
      ev = (j >= 0) && tbl[j].vld && !tbl[j].we;
      if (ev) exp_hold = tbl[j].exp;
      check($sformatf("%s_v%0d_valid", tag, i), {31'd0, bus.RSP_VALID}, {31'd0, ev});
      check($sformatf("%s_v%0d_rdata", tag, i), {16'd0, bus.RSP_RDATA}, {16'd0, exp_hold});
    end
    drive_idle();
    tbl.delete();
  endtask

  initial begin
    RST = 1'b1;
    drive_idle();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", {31'd0, bus.REQ_READY}, 0);
    check("rst_rsp_valid", {31'd0, bus.RSP_VALID}, 0);
    check("rst_init_done", {31'd0, bus.INIT_DONE}, 0);
    check("rst_rdata", {16'd0, bus.RSP_RDATA}, 0);

    wait_init("first");
    exp_hold = 16'h0000;

    // Zero-fill corners of both rows
    add(1, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    add(1, 0, 2'b00, 8'h7F, 16'h0000, 16'h0000);
    add(1, 0, 2'b00, 8'h80, 16'h0000, 16'h0000);
    add(1, 0, 2'b00, 8'hFF, 16'h0000, 16'h0000);
    // Byte enables; BE=00 write is a no-op
    add(1, 1, 2'b11, 8'h85, 16'hA5C3, 16'h0000);
    add(1, 1, 2'b01, 8'h85, 16'h00FF, 16'h0000);
    add(1, 0, 2'b00, 8'h85, 16'h0000, 16'hA5FF);
    add(1, 1, 2'b00, 8'h85, 16'h1234, 16'h0000);
    add(1, 0, 2'b00, 8'h85, 16'h0000, 16'hA5FF);
    // Row isolation, back-to-back reads, then hold
    add(1, 1, 2'b11, 8'h05, 16'h1111, 16'h0000);
    add(1, 1, 2'b11, 8'h85, 16'h2222, 16'h0000);
    add(1, 0, 2'b00, 8'h05, 16'h0000, 16'h1111);
    add(1, 0, 2'b00, 8'h85, 16'h0000, 16'h2222);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    // Write then immediate read
    add(1, 1, 2'b11, 8'hFF, 16'hBEEF, 16'h0000);
    add(1, 0, 2'b00, 8'hFF, 16'h0000, 16'hBEEF);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    // Write during a response cycle must not disturb RSP_RDATA
    add(1, 0, 2'b00, 8'h05, 16'h0000, 16'h1111);
    add(1, 1, 2'b11, 8'h05, 16'h3333, 16'h0000);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    add(1, 0, 2'b00, 8'h05, 16'h0000, 16'h3333);
    // Upper byte only
    add(1, 1, 2'b10, 8'h85, 16'hABCD, 16'h0000);
    add(1, 0, 2'b00, 8'h85, 16'h0000, 16'hAB22);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    run_table("main");

    // Reset abort: accept a read, then reset on the next edge
    @(negedge CLK);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = 8'hFF;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("abort_valid_%0d", k), {31'd0, bus.RSP_VALID}, 0);
    end
    check("abort_init_done", {31'd0, bus.INIT_DONE}, 0);
    check("abort_rdata", {16'd0, bus.RSP_RDATA}, 0);

    wait_init("second");
    exp_hold = 16'h0000;
    add(1, 0, 2'b00, 8'hFF, 16'h0000, 16'h0000);
    add(1, 0, 2'b00, 8'h85, 16'h0000, 16'h0000);
    add(1, 0, 2'b00, 8'h05, 16'h0000, 16'h0000);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    add(0, 0, 2'b00, 8'h00, 16'h0000, 16'h0000);
    run_table("refill");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
